// File: rtl/regfile_write_arbiter_if.sv
// Register-file write arbitration bundle: writeback port A, long-unit port B,
// issue tracking and the arbitrated register-file write outputs.
interface regfile_write_arbiter_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
);
  localparam int REG_W = $clog2(NUM_REGS);

  logic                Wb_Valid;
  logic [REG_W-1:0]    Wb_Reg;
  logic [DATA_W-1:0]   Wb_Data;
  logic                B_Valid;
  logic [REG_W-1:0]    B_Reg;
  logic [DATA_W-1:0]   B_Data;
  logic                B_Ready;
  logic                Issue_Valid;
  logic [REG_W-1:0]    Issue_Reg;
  logic                Write_En;
  logic [REG_W-1:0]    Write_Reg;
  logic [DATA_W-1:0]   Write_Data;
  logic [NUM_REGS-1:0] Pending_Mask;
  logic                Stall_Pipe;
  logic                Proto_Err;

  modport slave (
    input  Wb_Valid, Wb_Reg, Wb_Data,
    input  B_Valid, B_Reg, B_Data,
    input  Issue_Valid, Issue_Reg,
    output B_Ready, Write_En, Write_Reg, Write_Data,
    output Pending_Mask, Stall_Pipe, Proto_Err
  );

  modport master (
    output Wb_Valid, Wb_Reg, Wb_Data,
    output B_Valid, B_Reg, B_Data,
    output Issue_Valid, Issue_Reg,
    input  B_Ready, Write_En, Write_Reg, Write_Data,
    input  Pending_Mask, Stall_Pipe, Proto_Err
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares one register-file write port between pipeline writeback (A) and a long-latency unit (B).
// Optional macro RF_ARB_B_PRIORITY_EN: B wins in NORMAL, combinational stall, no starvation guard.
module regfile_write_arbiter #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_write_arbiter_if.slave  bus
);
  localparam int REG_W = $clog2(NUM_REGS);

  logic                grant_a_s;
  logic                grant_b_s;
  logic                b_ready_s;
  logic                proto_set_s;
  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] pending_next_s;
  logic                write_en_r;
  logic [REG_W-1:0]    write_reg_r;
  logic [DATA_W-1:0]   write_data_r;
  logic                proto_err_r;

`ifdef RF_ARB_B_PRIORITY_EN
  // B always wins; A is only granted when B is idle
  always_comb begin
    grant_b_s   = bus.B_Valid;
    grant_a_s   = bus.Wb_Valid & ~bus.B_Valid;
    b_ready_s   = bus.B_Valid;
    proto_set_s = grant_a_s & pending_r[bus.Wb_Reg];
  end

  assign bus.Stall_Pipe = bus.B_Valid;
`else
  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT - 1);

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] wait_cnt_r;
  logic [3:0] wait_cnt_next_s;
  logic       force_drop_s;

  // Arbitration, starvation counter and NORMAL/FORCE next-state
  always_comb begin
    grant_a_s       = 1'b0;
    grant_b_s       = 1'b0;
    b_ready_s       = 1'b0;
    force_drop_s    = 1'b0;
    state_next_s    = state_r;
    wait_cnt_next_s = 4'd0;
    case (state_r)
      ST_NORMAL: begin
        grant_a_s = bus.Wb_Valid;
        grant_b_s = ~bus.Wb_Valid & bus.B_Valid;
        b_ready_s = grant_b_s;
        if (bus.B_Valid && !b_ready_s) begin
          // Reaching the limit on this refusal forces the pipeline to yield next cycle
          if (wait_cnt_r >= WAIT_LIMIT - 4'd1) begin
            wait_cnt_next_s = WAIT_LIMIT;
            state_next_s    = ST_FORCE;
          end else begin
            wait_cnt_next_s = wait_cnt_r + 4'd1;
            state_next_s    = ST_NORMAL;
          end
        end else begin
          wait_cnt_next_s = 4'd0;
          state_next_s    = ST_NORMAL;
        end
      end
      ST_FORCE: begin
        grant_b_s       = bus.B_Valid;
        b_ready_s       = bus.B_Valid;
        force_drop_s    = bus.Wb_Valid;
        wait_cnt_next_s = 4'd0;
        state_next_s    = ST_NORMAL;
      end
      default: begin
        wait_cnt_next_s = 4'd0;
        state_next_s    = ST_NORMAL;
      end
    endcase
    proto_set_s = force_drop_s | (grant_a_s & pending_r[bus.Wb_Reg]);
  end

  // FSM state and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_NORMAL;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  assign bus.Stall_Pipe = (state_r == ST_FORCE);
`endif

  // Scoreboard update: a same-cycle issue overrides the clear
  always_comb begin
    pending_next_s = pending_r;
    for (int r = 0; r < NUM_REGS; r++) begin
      pending_next_s[r] =
          (pending_r[r] & ~(bus.B_Valid & b_ready_s & (bus.B_Reg == REG_W'(r))))
        | (bus.Issue_Valid & (bus.Issue_Reg == REG_W'(r)));
    end
  end

  // Pending scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_next_s;
    end
  end

  // Registered register-file write port; idle cycles hold address and data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en_r   <= 1'b0;
      write_reg_r  <= '0;
      write_data_r <= '0;
    end else if (grant_a_s) begin
      write_en_r   <= 1'b1;
      write_reg_r  <= bus.Wb_Reg;
      write_data_r <= bus.Wb_Data;
    end else if (grant_b_s) begin
      write_en_r   <= 1'b1;
      write_reg_r  <= bus.B_Reg;
      write_data_r <= bus.B_Data;
    end else begin
      write_en_r   <= 1'b0;
    end
  end

  // Sticky protocol error, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_r <= 1'b0;
    end else if (proto_set_s) begin
      proto_err_r <= 1'b1;
    end else begin
      proto_err_r <= proto_err_r;
    end
  end

  assign bus.B_Ready      = b_ready_s;
  assign bus.Write_En     = write_en_r;
  assign bus.Write_Reg    = write_reg_r;
  assign bus.Write_Data   = write_data_r;
  assign bus.Pending_Mask = pending_r;
  assign bus.Proto_Err    = proto_err_r;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (default build, MAX_WAIT=4) with a write scoreboard.
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  typedef struct {
    logic [2:0]  r;
    logic [15:0] d;
    int          due;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  regfile_write_arbiter_if #(.DATA_W(16), .NUM_REGS(8)) bus ();

  regfile_write_arbiter #(.DATA_W(16), .NUM_REGS(8), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [2:0] wr, input logic [15:0] wd,
                       input logic bv, input logic [2:0] br, input logic [15:0] bd,
                       input logic iv, input logic [2:0] ir);
    bus.Wb_Valid    = wv;
    bus.Wb_Reg      = wr;
    bus.Wb_Data     = wd;
    bus.B_Valid     = bv;
    bus.B_Reg       = br;
    bus.B_Data      = bd;
    bus.Issue_Valid = iv;
    bus.Issue_Reg   = ir;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
  endtask

  // Expected write lands one cycle after the grant cycle being driven now
  task automatic push_wr(input logic [2:0] r, input logic [15:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    e.due = cyc + 1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus.Write_En === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_en", 32'(bus.Write_En), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_reg", 32'(bus.Write_Reg), 32'(mon_e.r));
        chk("write_data", 32'(bus.Write_Data), 32'(mon_e.d));
        chk("write_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 3'd7, 16'hFFFF, 1'b1, 3'd6, 16'hEEEE, 1'b1, 3'd5);
    repeat (3) @(negedge clk);
    chk("reset_write_en", 32'(bus.Write_En), 32'd0);
    chk("reset_write_reg", 32'(bus.Write_Reg), 32'd0);
    chk("reset_write_data", 32'(bus.Write_Data), 32'd0);
    chk("reset_pending", 32'(bus.Pending_Mask), 32'd0);
    chk("reset_stall", 32'(bus.Stall_Pipe), 32'd0);
    chk("reset_proto", 32'(bus.Proto_Err), 32'd0);
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_no_write", 32'(bus.Write_En), 32'd0);

    // A only
    drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    push_wr(3'd3, 16'h1234);
    #1 chk("a_only_b_ready", 32'(bus.B_Ready), 32'd0);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("hold_write_en", 32'(bus.Write_En), 32'd0);
    chk("hold_write_reg", 32'(bus.Write_Reg), 32'd3);
    chk("hold_write_data", 32'(bus.Write_Data), 32'h1234);

    // Contention: A wins three cycles, then FORCE grants B
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(i + 1), 16'(16'h1000 + i), 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0);
      push_wr(3'(i + 1), 16'(16'h1000 + i));
      #1;
      chk("cont_b_ready", 32'(bus.B_Ready), 32'd0);
      chk("cont_stall", 32'(bus.Stall_Pipe), 32'd0);
      @(negedge clk);
    end
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0);
    push_wr(3'd5, 16'hBEEF);
    #1;
    chk("force_stall", 32'(bus.Stall_Pipe), 32'd1);
    chk("force_b_ready", 32'(bus.B_Ready), 32'd1);
    @(negedge clk);
    idle();
    #1;
    chk("force_exit_stall", 32'(bus.Stall_Pipe), 32'd0);
    chk("cont_no_proto", 32'(bus.Proto_Err), 32'd0);

    // Scoreboard
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2);
    @(negedge clk);
    idle();
    chk("pend_issue2", 32'(bus.Pending_Mask), 32'h04);
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h2222, 1'b1, 3'd2);
    push_wr(3'd2, 16'h2222);
    #1 chk("pend_b_ready", 32'(bus.B_Ready), 32'd1);
    @(negedge clk);
    idle();
    chk("pend_set_wins", 32'(bus.Pending_Mask), 32'h04);
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h3333, 1'b0, 3'd0);
    push_wr(3'd2, 16'h3333);
    @(negedge clk);
    idle();
    chk("pend_clear2", 32'(bus.Pending_Mask), 32'h00);
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 16'h7777, 1'b0, 3'd0);
    push_wr(3'd7, 16'h7777);
    @(negedge clk);
    idle();
    chk("pend_unpended_b", 32'(bus.Pending_Mask), 32'h00);
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6);
    @(negedge clk);
    chk("pend_issue6", 32'(bus.Pending_Mask), 32'h40);
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6);
    @(negedge clk);
    idle();
    chk("pend_reissue6", 32'(bus.Pending_Mask), 32'h40);
    chk("pend_reissue_no_proto", 32'(bus.Proto_Err), 32'd0);
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h6666, 1'b0, 3'd0);
    push_wr(3'd6, 16'h6666);
    @(negedge clk);
    idle();
    chk("pend_clear6", 32'(bus.Pending_Mask), 32'h00);

    // Wb_Valid held into FORCE: A dropped, Proto_Err set
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(i), 16'(16'h2000 + i), 1'b1, 3'd0, 16'h5A5A, 1'b0, 3'd0);
      push_wr(3'(i), 16'(16'h2000 + i));
      @(negedge clk);
    end
    drive(1'b1, 3'd1, 16'hDEAD, 1'b1, 3'd0, 16'h5A5A, 1'b0, 3'd0);
    push_wr(3'd0, 16'h5A5A);
    #1 chk("drop_stall", 32'(bus.Stall_Pipe), 32'd1);
    @(negedge clk);
    idle();
    chk("drop_proto", 32'(bus.Proto_Err), 32'd1);
    @(negedge clk);
    chk("drop_proto_sticky", 32'(bus.Proto_Err), 32'd1);

    // Async reset in the middle of a FORCE cycle
    drive(1'b1, 3'd1, 16'h3000, 1'b1, 3'd4, 16'h4444, 1'b1, 3'd3);
    push_wr(3'd1, 16'h3000);
    @(negedge clk);
    for (int i = 1; i < 3; i++) begin
      drive(1'b1, 3'(i + 1), 16'(16'h3000 + i), 1'b1, 3'd4, 16'h4444, 1'b0, 3'd0);
      push_wr(3'(i + 1), 16'(16'h3000 + i));
      @(negedge clk);
    end
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h4444, 1'b0, 3'd0);
    #1;
    chk("pre_rst_stall", 32'(bus.Stall_Pipe), 32'd1);
    chk("pre_rst_write_en", 32'(bus.Write_En), 32'd1);
    chk("pre_rst_pending", 32'(bus.Pending_Mask), 32'h08);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_stall", 32'(bus.Stall_Pipe), 32'd0);
    chk("rst_write_en", 32'(bus.Write_En), 32'd0);
    chk("rst_pending", 32'(bus.Pending_Mask), 32'h00);
    chk("rst_proto", 32'(bus.Proto_Err), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Port-A write to a pending register
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2);
    @(negedge clk);
    drive(1'b1, 3'd2, 16'hAAAA, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    push_wr(3'd2, 16'hAAAA);
    chk("pend_a_proto_before", 32'(bus.Proto_Err), 32'd0);
    @(negedge clk);
    idle();
    chk("pend_a_proto", 32'(bus.Proto_Err), 32'd1);
    chk("pend_a_mask_kept", 32'(bus.Pending_Mask), 32'h04);
    @(negedge clk);
    chk("pend_a_proto_sticky", 32'(bus.Proto_Err), 32'd1);

    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
